// File: rtl/btb_sa_if.sv
// Purpose: lookup/update/flush signal bundle between fetch/execute and the branch target buffer.
// Latency: wires only; response timing is defined by btb_sa.
// Backpressure: none; every valid request is accepted in the cycle it is presented.
//
// Ports (master drives requests, slave drives responses):
//   lk_valid, lk_pc                          lookup request
//   lk_rsp_valid, lk_hit, lk_taken, lk_target lookup response, one cycle later
//   up_valid, up_pc, up_taken, up_target     resolved-branch update
//   flush                                    invalidate all entries
interface btb_sa_if #(
  parameter int XLEN = 64
);
  logic            lk_valid;
  logic [XLEN-1:0] lk_pc;
  logic            lk_rsp_valid;
  logic            lk_hit;
  logic            lk_taken;
  logic [XLEN-1:0] lk_target;
  logic            up_valid;
  logic [XLEN-1:0] up_pc;
  logic            up_taken;
  logic [XLEN-1:0] up_target;
  logic            flush;

  modport master (
    output lk_valid, lk_pc, up_valid, up_pc, up_taken, up_target, flush,
    input  lk_rsp_valid, lk_hit, lk_taken, lk_target
  );

  modport slave (
    input  lk_valid, lk_pc, up_valid, up_pc, up_taken, up_target, flush,
    output lk_rsp_valid, lk_hit, lk_taken, lk_target
  );
endinterface

// File: rtl/btb_sa.sv
// Purpose: set-associative branch target buffer with 2-bit saturating direction counters.
// Latency: lookup response registered, one cycle after lk_valid; updates take effect at the sampling edge.
// Backpressure: none; one lookup and one update accepted every cycle.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   bif (slave)  lookup request/response, update and flush (see btb_sa_if)
// Optional build macro: BTB_BYPASS_EN -- a same-cycle update to the looked-up
// index+tag is forwarded into the lookup response (post-update view).
// Without it the lookup always sees pre-update state (read-before-write).
// Assumes SETS = ENTRIES/WAYS >= 2 so the index field is at least one bit wide.
module btb_sa #(
  parameter int         XLEN     = 64,
  parameter int         ENTRIES  = 512,
  parameter int         WAYS     = 4,
  parameter logic [1:0] CNT_INIT = 2'd2
) (
  input logic      clk,
  input logic      rst,
  btb_sa_if.slave  bif
);
  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - 2;
  // WAYS=1 keeps a 1-bit pointer that is never advanced (always 0).
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Entry storage
  logic             valid_q [SETS][WAYS];
  logic             valid_d [SETS][WAYS];
  logic [1:0]       ctr_q   [SETS][WAYS];
  logic [1:0]       ctr_d   [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_d   [SETS][WAYS];
  logic [XLEN-1:0]  tgt_q   [SETS][WAYS];
  logic [XLEN-1:0]  tgt_d   [SETS][WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];
  logic [WAY_W-1:0] rr_d    [SETS];

  // Response registers
  logic            rsp_valid_q, rsp_valid_d;
  logic            hit_q, hit_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             unused_pc_bits;

  assign lk_idx = bif.lk_pc[IDX_W+1:2];
  assign lk_tag = bif.lk_pc[XLEN-1:IDX_W+2];
  assign up_idx = bif.up_pc[IDX_W+1:2];
  assign up_tag = bif.up_pc[XLEN-1:IDX_W+2];
  // Instruction alignment bits carry no information for the BTB.
  assign unused_pc_bits = ^{bif.lk_pc[1:0], bif.up_pc[1:0]};

  // Lookup read of the current (pre-update) state
  logic            lk_hit_w;
  logic [1:0]      lk_ctr_w;
  logic [XLEN-1:0] lk_tgt_w;

  always_comb begin
    lk_hit_w = 1'b0;
    lk_ctr_w = 2'd0;
    lk_tgt_w = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit_w = 1'b1;
        lk_ctr_w = ctr_q[lk_idx][w];
        lk_tgt_w = tgt_q[lk_idx][w];
      end
    end
  end

  // Update-side match and victim selection
  logic             up_hit;
  logic [WAY_W-1:0] up_way;
  logic [1:0]       up_hit_ctr;
  logic [XLEN-1:0]  up_hit_tgt;
  logic             has_free;
  logic [WAY_W-1:0] vic_way;

  always_comb begin
    up_hit     = 1'b0;
    up_way     = '0;
    up_hit_ctr = 2'd0;
    up_hit_tgt = '0;
    has_free   = 1'b0;
    vic_way    = rr_q[up_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
        up_hit     = 1'b1;
        up_way     = WAY_W'(w);
        up_hit_ctr = ctr_q[up_idx][w];
        up_hit_tgt = tgt_q[up_idx][w];
      end
    end
    // Lowest-numbered invalid way wins over the round-robin pointer.
    for (int w = 0; w < WAYS; w++) begin
      if (!has_free && !valid_q[up_idx][w]) begin
        has_free = 1'b1;
        vic_way  = WAY_W'(w);
      end
    end
  end

  // Post-update entry contents; also used by the bypass path.
  logic            up_apply;
  logic [1:0]      up_new_ctr;
  logic [XLEN-1:0] up_new_tgt;

  always_comb begin
    // A not-taken miss changes nothing; flush drops the update.
    up_apply = bif.up_valid && !bif.flush && (up_hit || bif.up_taken);
    if (!up_hit) begin
      up_new_ctr = CNT_INIT;
    end else if (bif.up_taken) begin
      up_new_ctr = (up_hit_ctr == 2'd3) ? 2'd3 : up_hit_ctr + 2'd1;
    end else begin
      up_new_ctr = (up_hit_ctr == 2'd0) ? 2'd0 : up_hit_ctr - 2'd1;
    end
    up_new_tgt = bif.up_taken ? bif.up_target : up_hit_tgt;
  end

  // Next state of the storage arrays
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    rr_d    = rr_q;
    if (bif.flush) begin
      for (int s = 0; s < SETS; s++) begin
        rr_d[s] = '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_d[s][w] = 1'b0;
        end
      end
    end else if (up_apply) begin
      if (up_hit) begin
        ctr_d[up_idx][up_way] = up_new_ctr;
        tgt_d[up_idx][up_way] = up_new_tgt;
      end else begin
        valid_d[up_idx][vic_way] = 1'b1;
        tag_d[up_idx][vic_way]   = up_tag;
        tgt_d[up_idx][vic_way]   = up_new_tgt;
        ctr_d[up_idx][vic_way]   = up_new_ctr;
        // Pointer only moves when a live entry was displaced.
        if (!has_free && WAYS > 1) begin
          rr_d[up_idx] = rr_q[up_idx] + WAY_W'(1);
        end
      end
    end
  end

  // Lookup response next state
  logic            eff_hit;
  logic [1:0]      eff_ctr;
  logic [XLEN-1:0] eff_tgt;

  always_comb begin
`ifdef BTB_BYPASS_EN
    // Forward the entry being written this cycle when it is the one looked up.
    logic byp;
    byp     = up_apply && (lk_idx == up_idx) && (lk_tag == up_tag);
    eff_hit = lk_hit_w || byp;
    eff_ctr = byp ? up_new_ctr : lk_ctr_w;
    eff_tgt = byp ? up_new_tgt : lk_tgt_w;
`else
    eff_hit = lk_hit_w;
    eff_ctr = lk_ctr_w;
    eff_tgt = lk_tgt_w;
`endif
    rsp_valid_d = bif.lk_valid;
    hit_d       = bif.lk_valid && !bif.flush && eff_hit;
    taken_d     = hit_d && eff_ctr[1];
    target_d    = hit_d ? eff_tgt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= 2'd0;
          tag_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
        end
      end
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      ctr_q       <= ctr_d;
      tag_q       <= tag_d;
      tgt_q       <= tgt_d;
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      hit_q       <= hit_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
    end
  end

  assign bif.lk_rsp_valid = rsp_valid_q;
  assign bif.lk_hit       = hit_q;
  assign bif.lk_taken     = taken_q;
  assign bif.lk_target    = target_q;
endmodule

// File: tb/tb_btb_sa.sv
// Purpose: directed self-checking bench for btb_sa (default 512 entries, 4 ways, 128 sets).
// Latency: drives one request per cycle and checks the response #1 after the next edge.
// Backpressure: none exercised; the design never stalls.
module tb_btb_sa;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  btb_sa_if #(.XLEN(64)) bif ();

  btb_sa #(
    .XLEN(64), .ENTRIES(512), .WAYS(4), .CNT_INIT(2'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bif(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bif.lk_valid  = 1'b0;
    bif.lk_pc     = '0;
    bif.up_valid  = 1'b0;
    bif.up_pc     = '0;
    bif.up_taken  = 1'b0;
    bif.up_target = '0;
    bif.flush     = 1'b0;
  endtask

  // One cycle of stimulus; returns #1 after the sampling edge with inputs idled.
  task automatic cyc(input logic lkv, input logic [63:0] lkpc,
                     input logic upv, input logic [63:0] uppc,
                     input logic upt, input logic [63:0] uptgt, input logic fl);
    bif.lk_valid  = lkv;
    bif.lk_pc     = lkpc;
    bif.up_valid  = upv;
    bif.up_pc     = uppc;
    bif.up_taken  = upt;
    bif.up_target = uptgt;
    bif.flush     = fl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic lookup(input logic [63:0] pc);
    cyc(1'b1, pc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic upd(input logic [63:0] pc, input logic t, input logic [63:0] tgt);
    cyc(1'b0, 64'h0, 1'b1, pc, t, tgt, 1'b0);
  endtask

  task automatic expect_rsp(input string tag, input logic h, input logic t, input logic [63:0] tgt);
    check({tag, ".vld"}, {63'h0, bif.lk_rsp_valid}, 64'h1);
    check({tag, ".hit"}, {63'h0, bif.lk_hit}, {63'h0, h});
    check({tag, ".tkn"}, {63'h0, bif.lk_taken}, {63'h0, t});
    check({tag, ".tgt"}, bif.lk_target, tgt);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #3;
    check("rst.vld", {63'h0, bif.lk_rsp_valid}, 64'h0);
    check("rst.hit", {63'h0, bif.lk_hit}, 64'h0);
    check("rst.tgt", bif.lk_target, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: cold lookup misses; idle cycle gives no response
    lookup(64'h1000);
    expect_rsp("t1.cold", 1'b0, 1'b0, 64'h0);
    cyc(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    check("t1.idle.vld", {63'h0, bif.lk_rsp_valid}, 64'h0);

    // 2: allocation and counter training on pc 0x1000 (set 0)
    upd(64'h1000, 1'b1, 64'h2000);
    lookup(64'h1000);
    expect_rsp("t2.alloc", 1'b1, 1'b1, 64'h2000);
    upd(64'h1000, 1'b0, 64'hBAD0);          // ctr 1, target kept
    lookup(64'h1000);
    expect_rsp("t2.nt1", 1'b1, 1'b0, 64'h2000);
    upd(64'h1000, 1'b0, 64'hBAD0);          // ctr 0
    upd(64'h1000, 1'b0, 64'hBAD0);          // ctr stays 0
    lookup(64'h1000);
    expect_rsp("t2.nt3", 1'b1, 1'b0, 64'h2000);
    upd(64'h1000, 1'b0, 64'hBAD0);          // still 0
    upd(64'h1000, 1'b1, 64'h2400);          // ctr 1, new target
    lookup(64'h1000);
    expect_rsp("t2.lowsat", 1'b1, 1'b0, 64'h2400);
    upd(64'h1000, 1'b1, 64'h2400);          // ctr 2
    upd(64'h1000, 1'b1, 64'h2400);          // ctr 3
    upd(64'h1000, 1'b1, 64'h2400);          // ctr stays 3
    upd(64'h1000, 1'b0, 64'hBAD0);          // ctr 2
    lookup(64'h1000);
    expect_rsp("t2.highsat", 1'b1, 1'b1, 64'h2400);
    upd(64'h1000, 1'b0, 64'hBAD0);          // ctr 1
    lookup(64'h1000);
    expect_rsp("t2.dec", 1'b1, 1'b0, 64'h2400);
    upd(64'h1E00, 1'b0, 64'h7000);          // not-taken miss: no allocation
    lookup(64'h1E00);
    expect_rsp("t2.ntmiss", 1'b0, 1'b0, 64'h0);

    // 3: fill set 0 (0x1000 already in way 0), then round-robin eviction
    upd(64'h1200, 1'b1, 64'h3200);
    upd(64'h1400, 1'b1, 64'h3400);
    upd(64'h1600, 1'b1, 64'h3600);
    upd(64'h1800, 1'b1, 64'h3800);          // evicts way 0 (0x1000), rr -> 1
    lookup(64'h1000);
    expect_rsp("t3.evict0", 1'b0, 1'b0, 64'h0);
    lookup(64'h1200);
    expect_rsp("t3.keep1", 1'b1, 1'b1, 64'h3200);
    lookup(64'h1600);
    expect_rsp("t3.keep3", 1'b1, 1'b1, 64'h3600);
    lookup(64'h1800);
    expect_rsp("t3.new", 1'b1, 1'b1, 64'h3800);
    upd(64'h1A00, 1'b1, 64'h3A00);          // evicts way 1 (0x1200), rr -> 2
    lookup(64'h1200);
    expect_rsp("t3.evict1", 1'b0, 1'b0, 64'h0);
    lookup(64'h1A00);
    expect_rsp("t3.new2", 1'b1, 1'b1, 64'h3A00);
    lookup(64'h1400);
    expect_rsp("t3.keep2", 1'b1, 1'b1, 64'h3400);

    // 5: flush with concurrent lookup of a live pc and a taken update
    cyc(1'b1, 64'h1400, 1'b1, 64'h5000, 1'b1, 64'h6000, 1'b1);
    expect_rsp("t5.flushcyc", 1'b0, 1'b0, 64'h0);
    lookup(64'h1400);
    expect_rsp("t5.old", 1'b0, 1'b0, 64'h0);
    lookup(64'h5000);
    expect_rsp("t5.upd", 1'b0, 1'b0, 64'h0);
    lookup(64'h1A00);
    expect_rsp("t5.other", 1'b0, 1'b0, 64'h0);

    // 4: same-cycle lookup + allocating update on an absent pc
    cyc(1'b1, 64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2222, 1'b0);
`ifdef BTB_BYPASS_EN
    expect_rsp("t4.same", 1'b1, 1'b1, 64'h2222);
`else
    expect_rsp("t4.same", 1'b0, 1'b0, 64'h0);
`endif
    lookup(64'h1000);
    expect_rsp("t4.after", 1'b1, 1'b1, 64'h2222);

    // 6: asynchronous reset with lookup held active
    bif.lk_valid = 1'b1;
    bif.lk_pc    = 64'h1000;
    @(posedge clk);
    #1;
    expect_rsp("t6.pre", 1'b1, 1'b1, 64'h2222);
    #2;
    rst = 1'b1;
    #1;
    check("t6.async.vld", {63'h0, bif.lk_rsp_valid}, 64'h0);
    check("t6.async.hit", {63'h0, bif.lk_hit}, 64'h0);
    check("t6.async.tgt", bif.lk_target, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_rsp("t6.post", 1'b0, 1'b0, 64'h0);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
